debouncer: RTL and testbench

//  N-channel debouncer with edge detection. Sits directly downstream of the 2-FF synchronizer.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_channel.sv | 107 ++++++++++
 rtl/debouncer.sv | 34 +++
 tb/tb_debouncer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and defaults for the debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_CHK_HIGH,
    DB_HIGH,
    DB_CHK_LOW
  } db_state_t;

  localparam int DB_DEFAULT_STABLE = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-bit debounce FSM with registered level and edge pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_DEFAULT_STABLE,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic in_bit,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("debounce_channel: STABLE_CYCLES must be >= 2");
    end
  endgenerate

  db_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DB_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Entering a CHK state counts the first differing sample, so commit happens at CNT_LAST.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (sample_en) begin
      case (r_state)
        DB_LOW: begin
          if (in_bit) begin
            w_state_nxt = DB_CHK_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        DB_CHK_HIGH: begin
          if (!in_bit) begin
            w_state_nxt = DB_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = DB_HIGH;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        DB_HIGH: begin
          if (!in_bit) begin
            w_state_nxt = DB_CHK_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        DB_CHK_LOW: begin
          if (in_bit) begin
            w_state_nxt = DB_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = DB_LOW;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = DB_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/debouncer.sv
// rtl/debouncer.sv - N independent debounce channels sharing one sample strobe
module debouncer
  import debounce_pkg::*;
#(
  parameter int N             = 8,
  parameter int STABLE_CYCLES = DB_DEFAULT_STABLE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_en,
  input  logic [N-1:0] in_sync,
  output logic [N-1:0] db_level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .in_bit   (in_sync[gi]),
      .level    (db_level[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi])
    );
  end

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - vector table, corner sequences and randomized reference check for debouncer
module tb_debouncer;

  localparam int N  = 8;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sample_en = 1'b1;
  logic [N-1:0] in_sync = '0;
  logic [N-1:0] db_level, rise, fall;

  int total = 0;
  int bad   = 0;

  debouncer #(.N(N), .STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .in_sync  (in_sync),
    .db_level (db_level),
    .rise     (rise),
    .fall     (fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in;
    logic       en;
    logic [7:0] lvl;
    logic [7:0] r;
    logic [7:0] f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] in, input logic en);
    in_sync   = in;
    sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference: a channel commits once SC consecutive enabled samples differ from its level.
  bit m_level[N];
  int m_run[N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_level[i] = 1'b0;
      m_run[i]   = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] in, input logic en,
                            output logic [7:0] lvl, output logic [7:0] r, output logic [7:0] f);
    r = '0;
    f = '0;
    for (int i = 0; i < N; i++) begin
      if (en) begin
        if (in[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_level[i] = in[i];
            m_run[i]   = 0;
            if (in[i]) r[i] = 1'b1;
            else       f[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      lvl[i] = m_level[i];
    end
  endtask

  initial begin
    logic [7:0] cur, mask, el, er, ef;
    logic       en;

    // Async reset seen before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check("reset_level", db_level, 8'h00);
    check("reset_rise", rise, 8'h00);
    check("reset_fall", fall, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Clean rise, glitch, gap restart, multi-channel rise and fall
    vecs.push_back('{8'h01, 1'b1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 8'h01, 8'h01, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h03, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h03, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h03, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h05, 8'h04, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h05, 8'h00, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 8'h05, 8'h00, 8'h00});
    vecs.push_back('{8'hFF, 1'b0, 8'h05, 8'h00, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 8'h05, 8'h00, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 8'h05, 8'h00, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 8'hFF, 8'hFA, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 8'hFF, 8'h00, 8'h00});
    vecs.push_back('{8'h0F, 1'b1, 8'hFF, 8'h00, 8'h00});
    vecs.push_back('{8'h0F, 1'b1, 8'hFF, 8'h00, 8'h00});
    vecs.push_back('{8'h0F, 1'b1, 8'hFF, 8'h00, 8'h00});
    vecs.push_back('{8'h0F, 1'b1, 8'h0F, 8'h00, 8'hF0});
    vecs.push_back('{8'h0F, 1'b1, 8'h0F, 8'h00, 8'h00});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in, vecs[i].en);
      check($sformatf("vec%0d_level", i), db_level, vecs[i].lvl);
      check($sformatf("vec%0d_rise", i), rise, vecs[i].r);
      check($sformatf("vec%0d_fall", i), fall, vecs[i].f);
    end

    // Prescaled: strobe every 3rd cycle, commit on the 4th enabled sample
    for (int c = 0; c < 12; c++) begin
      step(8'h1F, (c % 3) == 2);
      check($sformatf("pre%0d_level", c), db_level, (c == 11) ? 8'h1F : 8'h0F);
      check($sformatf("pre%0d_rise", c), rise, (c == 11) ? 8'h10 : 8'h00);
      check($sformatf("pre%0d_fall", c), fall, 8'h00);
    end
    step(8'h1F, 1'b0);
    check("pre_after_rise", rise, 8'h00);
    check("pre_after_level", db_level, 8'h1F);

    // Reset with bit5 mid-count (two samples taken) and other channels HIGH
    step(8'h3F, 1'b1);
    step(8'h3F, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_level", db_level, 8'h00);
    check("rst_mid_rise", rise, 8'h00);
    check("rst_mid_fall", fall, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < SC + 1; c++) begin
      step(8'h3F, 1'b1);
      check($sformatf("rec%0d_level", c), db_level, (c >= SC - 1) ? 8'h3F : 8'h00);
      check($sformatf("rec%0d_rise", c), rise, (c == SC - 1) ? 8'h3F : 8'h00);
      check($sformatf("rec%0d_fall", c), fall, 8'h00);
    end

    // Randomized run against the reference
    in_sync = '0;
    do_reset();
    model_clear();
    cur = '0;
    for (int c = 0; c < 800; c++) begin
      mask = '0;
      for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 5) == 0);
      cur = cur ^ mask;
      en  = ($urandom_range(0, 3) != 0);
      step(cur, en);
      model_step(cur, en, el, er, ef);
      check("rnd_level", db_level, el);
      check("rnd_rise", rise, er);
      check("rnd_fall", fall, ef);
      check("rnd_excl", rise & fall, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
